// File: rtl/llc_rst_flush_sequencer.sv
// llc_rst_flush_sequencer
//
// Walks every LLC set in order and issues one set-operation per set to the
// LLC datapath. It serves either a reset walk or a flush walk. While a walk
// is in progress it publishes stall flags and the current set index, so the
// input decoder can prioritise resume work.
//
// Ports:
//   clk, rst                  clock; asynchronous active-low reset
//   rst_tb_valid/_flush/_ready
//                             reset/flush request channel (1 = flush);
//                             ready only while idle
//   hold                      blocks the first raise of op_valid
//   op_valid/_ready/_flush/_set/_last
//                             set-operation request to the datapath
//   op_done                   single-cycle completion of the accepted set-op
//   rst_stall, flush_stall    walk in progress, split by walk type
//   stalled_set               current walk position (same as op_set)
//   done_valid, done_flush    one-cycle completion pulse and its walk type
//   idle                      sequencer is idle
module llc_rst_flush_sequencer #(
  parameter int unsigned SET_BITS = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rst_tb_valid,
  input  logic                rst_tb_flush,
  output logic                rst_tb_ready,
  input  logic                hold,
  output logic                op_valid,
  input  logic                op_ready,
  output logic                op_flush,
  output logic [SET_BITS-1:0] op_set,
  output logic                op_last,
  input  logic                op_done,
  output logic                rst_stall,
  output logic                flush_stall,
  output logic [SET_BITS-1:0] stalled_set,
  output logic                done_valid,
  output logic                done_flush,
  output logic                idle
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [SET_BITS-1:0] SET_ONE = SET_BITS'(1);

  logic [1:0]          state_q, state_d;
  logic [SET_BITS-1:0] set_q, set_d;
  logic                flush_q, flush_d;
  // Once op_valid has been shown it must remain up until op_ready, even if
  // hold rises afterwards. This flag records that the request is already out.
  logic                raised_q, raised_d;

  logic issue_valid;

  assign issue_valid = (state_q == ST_ISSUE) && (raised_q || !hold);

  always_comb begin
    state_d  = state_q;
    set_d    = set_q;
    flush_d  = flush_q;
    raised_d = raised_q;
    case (state_q)
      ST_IDLE: begin
        if (rst_tb_valid) begin
          flush_d  = rst_tb_flush;
          set_d    = '0;
          raised_d = 1'b0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (issue_valid && op_ready) begin
          raised_d = 1'b0;
          state_d  = ST_WAIT;
        end else begin
          raised_d = issue_valid;
        end
      end
      ST_WAIT: begin
        if (op_done) begin
          if (&set_q) begin
            state_d = ST_DONE;
          end else begin
            set_d   = set_q + SET_ONE;
            state_d = ST_ISSUE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      set_q    <= '0;
      flush_q  <= 1'b0;
      raised_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      set_q    <= set_d;
      flush_q  <= flush_d;
      raised_q <= raised_d;
    end
  end

  // Stall flags cover every non-idle state, which runs from the cycle after
  // accept through the DONE cycle.
  logic busy;
  assign busy = (state_q != ST_IDLE);

  assign rst_tb_ready = !busy;
  assign idle         = !busy;
  assign op_valid     = issue_valid;
  assign op_flush     = flush_q;
  assign op_set       = set_q;
  assign op_last      = &set_q;
  assign stalled_set  = set_q;
  assign rst_stall    = busy && !flush_q;
  assign flush_stall  = busy && flush_q;
  assign done_valid   = (state_q == ST_DONE);
  assign done_flush   = (state_q == ST_DONE) && flush_q;

endmodule

// File: tb/tb_llc_rst_flush_sequencer.sv
// Testbench for llc_rst_flush_sequencer with SET_BITS = 2. A transaction-level
// model predicts the outputs, and a negedge compare process checks them every
// cycle. Directed sections pin the model with literal expectations. A long
// random section follows.
module tb_llc_rst_flush_sequencer;

  localparam int unsigned SB = 2;
  localparam int unsigned NSETS = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rst_tb_valid = 1'b0, rst_tb_flush = 1'b0, rst_tb_ready;
  logic          hold = 1'b0, op_valid, op_ready = 1'b0, op_flush;
  logic [SB-1:0] op_set, stalled_set;
  logic          op_last, op_done = 1'b0;
  logic          rst_stall, flush_stall, done_valid, done_flush, idle;

  int checks = 0;
  int failures = 0;

  llc_rst_flush_sequencer #(.SET_BITS(SB)) dut (
    .clk(clk), .rst(rst),
    .rst_tb_valid(rst_tb_valid), .rst_tb_flush(rst_tb_flush),
    .rst_tb_ready(rst_tb_ready), .hold(hold),
    .op_valid(op_valid), .op_ready(op_ready), .op_flush(op_flush),
    .op_set(op_set), .op_last(op_last), .op_done(op_done),
    .rst_stall(rst_stall), .flush_stall(flush_stall),
    .stalled_set(stalled_set), .done_valid(done_valid),
    .done_flush(done_flush), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a walk is a busy window that ends with a one-cycle
  // finish. Inside it, each set is first offered and then awaited.
  bit m_busy, m_flush, m_wait_done, m_finish, m_shown;
  int m_set;

  function automatic bit m_op_valid();
    return m_busy && !m_finish && !m_wait_done && (m_shown || !hold);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_flush = 0; m_wait_done = 0; m_finish = 0; m_shown = 0;
      m_set = 0;
    end else if (!m_busy) begin
      if (rst_tb_valid) begin
        m_busy = 1; m_flush = rst_tb_flush; m_set = 0;
        m_wait_done = 0; m_shown = 0;
      end
    end else if (m_finish) begin
      m_busy = 0; m_finish = 0;
    end else if (m_wait_done) begin
      if (op_done) begin
        m_wait_done = 0;
        if (m_set == NSETS - 1) m_finish = 1;
        else m_set = m_set + 1;
      end
    end else begin
      if (m_op_valid() && op_ready) begin
        m_wait_done = 1; m_shown = 0;
      end else begin
        m_shown = m_op_valid();
      end
    end
  end

  always @(negedge clk) begin
    check("rst_tb_ready", int'(rst_tb_ready), int'(!m_busy));
    check("idle", int'(idle), int'(!m_busy));
    check("op_valid", int'(op_valid), int'(m_op_valid()));
    check("op_set", int'(op_set), m_set);
    check("stalled_set", int'(stalled_set), m_set);
    check("op_last", int'(op_last), int'(m_set == NSETS - 1));
    check("rst_stall", int'(rst_stall), int'(m_busy && !m_flush));
    check("flush_stall", int'(flush_stall), int'(m_busy && m_flush));
    check("done_valid", int'(done_valid), int'(m_finish));
    if (m_op_valid()) check("op_flush", int'(op_flush), int'(m_flush));
    if (m_finish) check("done_flush", int'(done_flush), int'(m_flush));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int lat, nseen, seen[8];
  bit got;

  initial begin
    // Reset values
    #3;
    check("rst_ready_lit", int'(rst_tb_ready), 1);
    check("rst_idle_lit", int'(idle), 1);
    check("rst_op_set_lit", int'(op_set), 0);
    check("rst_done_lit", int'(done_valid), 0);
    tick();
    rst = 1'b1;
    tick();

    // Basic reset walk at minimum latency; op_done held high is ignored in ISSUE
    op_ready = 1; op_done = 1; hold = 0;
    rst_tb_valid = 1; rst_tb_flush = 0;
    tick();
    rst_tb_valid = 0;
    lat = 0; nseen = 0; got = 0;
    for (int k = 1; k <= 30 && !got; k++) begin
      #1;
      if (done_valid) begin
        got = 1; lat = k;
        check("walk_done_flush_lit", int'(done_flush), 0);
      end else begin
        if (op_valid && nseen < 8) begin seen[nseen] = int'(op_set); nseen++; end
        tick();
      end
    end
    check("walk_latency_lit", lat, 9);
    check("walk_nsets_lit", nseen, 4);
    for (int i = 0; i < 4; i++) check("walk_set_order_lit", seen[i], i);
    tick();
    check("walk_idle_after_lit", int'(idle), 1);

    // Reset mid-walk: stop in WAIT at set 2, then assert rst asynchronously
    op_done = 0;
    rst_tb_valid = 1; rst_tb_flush = 1;
    tick();
    rst_tb_valid = 0;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      op_done = (op_set != 2'd2) && !op_valid;
      tick();
      #1;
      if (op_set == 2'd2 && !op_valid && !idle) got = 1;
    end
    check("reach_wait_set2", int'(got), 1);
    op_done = 0;
    rst = 0;
    #1;
    check("midrst_flush_stall_lit", int'(flush_stall), 0);
    check("midrst_op_set_lit", int'(op_set), 0);
    check("midrst_idle_lit", int'(idle), 1);
    check("midrst_done_lit", int'(done_valid), 0);
    tick();
    rst = 1;
    tick();

    // Back-to-back: flush request held valid throughout a reset walk
    op_ready = 1; op_done = 1; hold = 0;
    rst_tb_valid = 1; rst_tb_flush = 0;
    tick();
    rst_tb_flush = 1;
    got = 0;
    for (int k = 0; k < 30 && !got; k++) begin
      #1;
      if (done_valid) got = 1; else tick();
    end
    check("b2b_done_seen", int'(got), 1);
    tick();
    #1;
    check("b2b_ready_lit", int'(rst_tb_ready), 1);
    tick();
    #1;
    check("b2b_flush_stall_lit", int'(flush_stall), 1);
    check("b2b_rst_stall_lit", int'(rst_stall), 0);
    rst_tb_valid = 0;

    // Random traffic covers hold, back-pressure, spurious op_done/requests, resets
    for (int n = 0; n < 4000; n++) begin
      tick();
      rst_tb_valid = ($urandom_range(0, 3) == 0);
      rst_tb_flush = $urandom_range(0, 1) == 1;
      hold         = ($urandom_range(0, 3) == 0);
      op_ready     = ($urandom_range(0, 9) < 6);
      op_done      = ($urandom_range(0, 9) < 3);
      if (!rst) rst = 1;
      else if ($urandom_range(0, 299) == 0) rst = 0;
    end
    tick();
    rst = 1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
